div_iter_2n_by_n: RTL and testbench



---
 rtl/div_iter_2n_by_n_pkg.sv | 19 +
 rtl/div_iter_2n_by_n_div_step.sv | 34 +++
 rtl/div_iter_2n_by_n.sv | 113 +++++++++++
 tb/tb_div_iter_2n_by_n.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_2n_by_n_pkg.sv
// Shared types and constants for the iterative 2N-by-N restoring divider.
package div_iter_2n_by_n_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // One extra bit so the counter can hold N itself without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_iter_2n_by_n_div_step.sv
// One radix-2 restoring step: shift {R,Q} left, try subtracting the divisor, keep or restore.
module div_iter_2n_by_n_div_step
    import div_iter_2n_by_n_pkg::*;
#(
    parameter int N = DIV_WIDTH
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [N+1:0] shifted_s;
    logic [N+1:0] trial_s;
    logic         negative_s;

    // Trial subtraction is one bit wider than R so its sign bit flags a borrow.
    always_comb begin
        shifted_s  = {r, q[N-1]};
        trial_s    = shifted_s - {2'b00, divisor};
        negative_s = trial_s[N+1];
        r_next     = {(N+1){1'b0}};
        q_next     = {q[N-2:0], 1'b0};
        if (negative_s) begin
            r_next    = shifted_s[N:0];
            q_next[0] = 1'b0;
        end else begin
            r_next    = trial_s[N:0];
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_iter_2n_by_n.sv
// Iterative unsigned 2N-by-N restoring divider, one quotient bit per clock, valid/ready on both sides.
module div_iter_2n_by_n
    import div_iter_2n_by_n_pkg::*;
#(
    parameter int N = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = cnt_width(N);

    div_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic [N:0]    rem_r;
    logic [N-1:0]  quo_r;
    logic [N-1:0]  dvs_r;
    logic [N:0]    rem_step_s;
    logic [N-1:0]  quo_step_s;

    div_iter_2n_by_n_div_step #(
        .N (N)
    ) u_div_step (
        .r       (rem_r),
        .q       (quo_r),
        .divisor (dvs_r),
        .r_next  (rem_step_s),
        .q_next  (quo_step_s)
    );

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            rem_r       <= {(N+1){1'b0}};
            quo_r       <= {N{1'b0}};
            dvs_r       <= {N{1'b0}};
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= {N{1'b0}};
            remainder   <= {N{1'b0}};
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        dvs_r    <= divisor;
                        if (divisor == {N{1'b0}}) begin
                            state_r     <= DONE;
                            out_valid   <= 1'b1;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= {N{1'b1}};
                            remainder   <= dividend[N-1:0];
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            // Upper half already >= divisor: quotient cannot fit in N bits.
                            state_r     <= DONE;
                            out_valid   <= 1'b1;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= {N{1'b1}};
                            remainder   <= {N{1'b0}};
                        end else begin
                            state_r <= RUN;
                            rem_r   <= {1'b0, dividend[2*N-1:N]};
                            quo_r   <= dividend[N-1:0];
                            cnt_r   <= {CW{1'b0}};
                        end
                    end
                end
                RUN: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(N - 1)) begin
                        state_r     <= DONE;
                        out_valid   <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        quotient    <= quo_step_s;
                        remainder   <= rem_step_s[N-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_2n_by_n.sv
// Randomized self-checking bench for div_iter_2n_by_n against a plain-arithmetic reference model.
module tb_div_iter_2n_by_n;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         dbz;
        logic         ovf;
        logic [N-1:0] q;
        logic [N-1:0] r;
    } res_t;

    res_t exp_q[$];

    div_iter_2n_by_n #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
        res_t m;
        logic [2*N-1:0] wide_dv;
        wide_dv = {{N{1'b0}}, dv};
        if (dv == 0) begin
            m.dbz = 1'b1; m.ovf = 1'b0; m.q = '1; m.r = dd[N-1:0];
        end else if (dd[2*N-1:N] >= dv) begin
            m.dbz = 1'b0; m.ovf = 1'b1; m.q = '1; m.r = '0;
        end else begin
            m.dbz = 1'b0; m.ovf = 1'b0;
            m.q = N'(dd / wide_dv);
            m.r = N'(dd % wide_dv);
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: whenever out_valid is high the outputs must equal the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_valid_exclusive", 64'(in_ready & out_valid), 64'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got out_valid=1 expected no result at %0t", $time);
                end else begin
                    chk("quotient",    64'(quotient),    64'(exp_q[0].q));
                    chk("remainder",   64'(remainder),   64'(exp_q[0].r));
                    chk("div_by_zero", 64'(div_by_zero), 64'(exp_q[0].dbz));
                    chk("overflow",    64'(overflow),    64'(exp_q[0].ovf));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input int hold);
        res_t m;
        int n;
        int exp_lat;
        m = model(dd, dv);
        exp_lat = (m.dbz || m.ovf) ? 1 : N + 1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_op", 64'(in_ready), 64'd1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        exp_q.push_back(m);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            chk("in_ready_backpressure", 64'(in_ready), 64'd0);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_handoff", 64'(in_ready), 64'd1);
        chk("out_valid_after_handoff", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t pm;
        logic [N-1:0]   dv;
        logic [N-1:0]   hi;
        int             sel;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_in_ready",    64'(in_ready),    64'd1);
        chk("reset_out_valid",   64'(out_valid),   64'd0);
        chk("reset_quotient",    64'(quotient),    64'd0);
        chk("reset_remainder",   64'(remainder),   64'd0);
        chk("reset_div_by_zero", 64'(div_by_zero), 64'd0);
        chk("reset_overflow",    64'(overflow),    64'd0);

        // Hand-computed expectations that pin the reference model.
        pm = model(64'd100, 32'd7);
        chk("pin_100_7", {pm.q, pm.r}, {32'd14, 32'd2});
        pm = model(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        chk("pin_maxprod", {pm.q, pm.r}, {32'hFFFF_FFFF, 32'd0});
        pm = model(64'h1234_5678_9ABC_DEF0, 32'd0);
        chk("pin_dbz", {30'd0, pm.dbz, pm.ovf, pm.q}, {30'd0, 2'b10, 32'hFFFF_FFFF});
        chk("pin_dbz_rem", 64'(pm.r), 64'h9ABC_DEF0);
        pm = model(64'h0000_0001_0000_0000, 32'd1);
        chk("pin_ovf", {30'd0, pm.dbz, pm.ovf, pm.r}, {30'd0, 2'b01, 32'd0});
        pm = model(64'd1000, 32'd3);
        chk("pin_1000_3", {pm.q, pm.r}, {32'd333, 32'd1});

        do_op(64'd100, 32'd7, 0);
        do_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0);
        do_op(64'h1234_5678_9ABC_DEF0, 32'd0, 1);
        do_op(64'h0000_0001_0000_0000, 32'd1, 0);
        do_op(64'h0000_0000_FFFF_FFFF, 32'd1, 0);
        do_op(64'd100, 32'd7, 5);

        // Abort in RUN: reset is sampled at the edge that would perform the 10th step.
        dividend = 64'h0000_0005_0000_0000;
        divisor  = 32'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid",   64'(out_valid),   64'd0);
        chk("abort_in_ready",    64'(in_ready),    64'd1);
        chk("abort_quotient",    64'(quotient),    64'd0);
        chk("abort_remainder",   64'(remainder),   64'd0);
        chk("abort_flags",       64'({div_by_zero, overflow}), 64'd0);
        do_op(64'd1000, 32'd3, 0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            dv  = $urandom;
            if (dv == 0) dv = 32'd1;
            if (sel == 0) begin
                dv = 32'd0;
                hi = $urandom;
            end else if (sel == 1) begin
                hi = (dv > 32'hFFFF_FFF0) ? dv : dv + 32'($urandom_range(0, 15));
            end else if (sel == 2) begin
                dv = 32'($urandom_range(1, 15));
                hi = $urandom % dv;
            end else begin
                hi = $urandom % dv;
            end
            do_op({hi, 32'($urandom)}, dv, $urandom_range(0, 3));
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
